sdram_port_arbiter: RTL and testbench

- Shares the single SDRAM controller request port between two memory masters: port 0 (CPU instruction/data bus) and port 1 (DMA/peripheral master).
- Also schedules periodic auto-refresh requests to the controller.
- Sits in main between the bus masters and the SDRAM controller.
- Uses round-robin arbitration, with refresh at top priority between transactions.

---
 rtl/sdram_arb_pkg.sv | 18 +
 rtl/sdram_refresh_timer.sv | 37 +++
 rtl/sdram_port_arbiter.sv | 129 ++++++++++++
 tb/tb_sdram_port_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// rtl/sdram_arb_pkg.sv - shared states and constants for the SDRAM port arbiter
package sdram_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GRANT0,
    GRANT1,
    REFRESH,
    DONE0,
    DONE1
  } arb_state_t;

  localparam logic PORT0     = 1'b0;
  localparam logic PORT1     = 1'b1;
  localparam logic NWE_WRITE = 1'b0;
  localparam logic NWE_READ  = 1'b1;

endpackage

// File: rtl/sdram_refresh_timer.sv
// rtl/sdram_refresh_timer.sv - free-running refresh interval counter with pending and sticky overrun flags
module sdram_refresh_timer #(
  parameter int REFRESH_INTERVAL = 390
) (
  input  logic clk,
  input  logic nreset,
  input  logic clear,
  output logic refresh_pending,
  output logic refresh_overrun
);

  localparam int              CW     = $clog2(REFRESH_INTERVAL);
  localparam logic [CW-1:0]   RELOAD = CW'(REFRESH_INTERVAL - 1);

  logic [CW-1:0] count;
  logic          expire;

  assign expire = (count == '0);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      count           <= RELOAD;
      refresh_pending <= 1'b0;
      refresh_overrun <= 1'b0;
    end else begin
      count <= expire ? RELOAD : count - 1'b1;
      // An expiry coinciding with the ack re-arms pending and is not an overrun.
      if (expire) begin
        refresh_pending <= 1'b1;
        if (refresh_pending && !clear) refresh_overrun <= 1'b1;
      end else if (clear) begin
        refresh_pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - two-port round-robin SDRAM request arbiter with refresh scheduling; SDRAM_ARB_FIXED_PRIORITY_EN makes port 0 always win ties
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDRESS_WIDTH    = 21,
  parameter int DATA_WIDTH       = 32,
  parameter int REFRESH_INTERVAL = 390
) (
  input  logic                      clk,
  input  logic                      nreset,
  input  logic                      p0_valid,
  input  logic                      p0_nwe,
  input  logic [ADDRESS_WIDTH-1:0]  p0_address,
  input  logic [DATA_WIDTH-1:0]     p0_wdata,
  input  logic [DATA_WIDTH/8-1:0]   p0_wstrb,
  output logic                      p0_ready,
  output logic [DATA_WIDTH-1:0]     p0_rdata,
  input  logic                      p1_valid,
  input  logic                      p1_nwe,
  input  logic [ADDRESS_WIDTH-1:0]  p1_address,
  input  logic [DATA_WIDTH-1:0]     p1_wdata,
  input  logic [DATA_WIDTH/8-1:0]   p1_wstrb,
  output logic                      p1_ready,
  output logic [DATA_WIDTH-1:0]     p1_rdata,
  output logic                      ctl_req,
  output logic                      ctl_refresh,
  output logic                      ctl_nwe,
  output logic [ADDRESS_WIDTH-1:0]  ctl_address,
  output logic [DATA_WIDTH-1:0]     ctl_wdata,
  output logic [DATA_WIDTH/8-1:0]   ctl_wstrb,
  input  logic                      ctl_ack,
  input  logic [DATA_WIDTH-1:0]     ctl_rdata,
  output logic                      refresh_overrun
);

  arb_state_t state, state_next;
  logic       last_grant, last_grant_next;
  logic       refresh_pending;
  logic       refresh_clear;

  assign refresh_clear = ctl_ack && (state == REFRESH);

  sdram_refresh_timer #(
    .REFRESH_INTERVAL(REFRESH_INTERVAL)
  ) u_refresh_timer (
    .clk             (clk),
    .nreset          (nreset),
    .clear           (refresh_clear),
    .refresh_pending (refresh_pending),
    .refresh_overrun (refresh_overrun)
  );

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state      <= IDLE;
      last_grant <= PORT1;
    end else begin
      state      <= state_next;
      last_grant <= last_grant_next;
    end
  end

  // last_grant only records the outcome of ties; single requests leave it alone.
  always_comb begin
    state_next      = state;
    last_grant_next = last_grant;
    case (state)
      IDLE: begin
        if (refresh_pending) begin
          state_next = REFRESH;
        end else if (p0_valid && p1_valid) begin
`ifdef SDRAM_ARB_FIXED_PRIORITY_EN
          state_next = GRANT0;
`else
          if (last_grant == PORT1) begin
            state_next      = GRANT0;
            last_grant_next = PORT0;
          end else begin
            state_next      = GRANT1;
            last_grant_next = PORT1;
          end
`endif
        end else if (p0_valid) begin
          state_next = GRANT0;
        end else if (p1_valid) begin
          state_next = GRANT1;
        end
      end
      GRANT0:  if (ctl_ack) state_next = DONE0;
      GRANT1:  if (ctl_ack) state_next = DONE1;
      REFRESH: if (ctl_ack) state_next = IDLE;
      DONE0:   state_next = IDLE;
      DONE1:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request fields are captured once at grant time and held until the ack.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      ctl_nwe     <= NWE_READ;
      ctl_address <= '0;
      ctl_wdata   <= '0;
      ctl_wstrb   <= '0;
      p0_rdata    <= '0;
      p1_rdata    <= '0;
    end else begin
      if (state == IDLE && state_next == GRANT0) begin
        ctl_nwe     <= p0_nwe;
        ctl_address <= p0_address;
        ctl_wdata   <= p0_wdata;
        ctl_wstrb   <= p0_wstrb;
      end else if (state == IDLE && state_next == GRANT1) begin
        ctl_nwe     <= p1_nwe;
        ctl_address <= p1_address;
        ctl_wdata   <= p1_wdata;
        ctl_wstrb   <= p1_wstrb;
      end
      if (state == GRANT0 && ctl_ack) p0_rdata <= ctl_rdata;
      if (state == GRANT1 && ctl_ack) p1_rdata <= ctl_rdata;
    end
  end

  assign ctl_req     = (state == GRANT0) || (state == GRANT1);
  assign ctl_refresh = (state == REFRESH);
  assign p0_ready    = (state == DONE0);
  assign p1_ready    = (state == DONE1);

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb/tb_sdram_port_arbiter.sv - directed and randomized checks of sdram_port_arbiter against a cycle-level behavioural model; honours SDRAM_ARB_FIXED_PRIORITY_EN
module tb_sdram_port_arbiter;

  localparam int AW = 21;
  localparam int DW = 32;
  localparam int RI = 16;

  logic          clk;
  logic          nreset;
  logic [1:0]    vld;
  logic [1:0]    nwe;
  logic [AW-1:0] addr  [2];
  logic [DW-1:0] wdata [2];
  logic [3:0]    wstrb [2];
  logic          p0_ready, p1_ready;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic          ctl_req, ctl_refresh, ctl_nwe;
  logic [AW-1:0] ctl_address;
  logic [DW-1:0] ctl_wdata;
  logic [3:0]    ctl_wstrb;
  logic          ctl_ack;
  logic [DW-1:0] ctl_rdata;
  logic          refresh_overrun;

  sdram_port_arbiter #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .REFRESH_INTERVAL(RI)
  ) dut (
    .clk(clk), .nreset(nreset),
    .p0_valid(vld[0]), .p0_nwe(nwe[0]), .p0_address(addr[0]), .p0_wdata(wdata[0]),
    .p0_wstrb(wstrb[0]), .p0_ready(p0_ready), .p0_rdata(p0_rdata),
    .p1_valid(vld[1]), .p1_nwe(nwe[1]), .p1_address(addr[1]), .p1_wdata(wdata[1]),
    .p1_wstrb(wstrb[1]), .p1_ready(p1_ready), .p1_rdata(p1_rdata),
    .ctl_req(ctl_req), .ctl_refresh(ctl_refresh), .ctl_nwe(ctl_nwe),
    .ctl_address(ctl_address), .ctl_wdata(ctl_wdata), .ctl_wstrb(ctl_wstrb),
    .ctl_ack(ctl_ack), .ctl_rdata(ctl_rdata), .refresh_overrun(refresh_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model phases: 0 idle, 1 serving a port, 2 refreshing, 3 handing back to a port.
  typedef struct {
    int            phase;
    int            port;
    bit            pending;
    bit            overrun;
    bit            last;
    int            edges;
    logic          nwe;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [3:0]    wstrb;
    logic [DW-1:0] rdata0;
    logic [DW-1:0] rdata1;
  } mstate_t;

  mstate_t m;

  function automatic mstate_t m_reset();
    mstate_t r;
    r.phase = 0; r.port = 0; r.pending = 0; r.overrun = 0; r.last = 1; r.edges = 0;
    r.nwe = 1'b1; r.addr = '0; r.wdata = '0; r.wstrb = '0; r.rdata0 = '0; r.rdata1 = '0;
    return r;
  endfunction

  function automatic mstate_t step(mstate_t s);
    mstate_t n;
    int      pick;
    bit      expire, clr;
    n = s;
    pick = -1;
    n.edges = s.edges + 1;
    expire = (n.edges % RI) == 0;
    clr = ctl_ack && (s.phase == 2);
    case (s.phase)
      0: begin
        if (s.pending) n.phase = 2;
        else if (vld[0] && vld[1]) begin
`ifdef SDRAM_ARB_FIXED_PRIORITY_EN
          pick = 0;
`else
          pick = s.last ? 0 : 1;
          n.last = (pick == 1);
`endif
        end else if (vld[0]) pick = 0;
        else if (vld[1]) pick = 1;
      end
      1: if (ctl_ack) begin
        if (s.port == 0) n.rdata0 = ctl_rdata; else n.rdata1 = ctl_rdata;
        n.phase = 3;
      end
      2: if (ctl_ack) n.phase = 0;
      default: n.phase = 0;
    endcase
    if (pick >= 0) begin
      n.phase = 1; n.port = pick;
      n.nwe = nwe[pick]; n.addr = addr[pick]; n.wdata = wdata[pick]; n.wstrb = wstrb[pick];
    end
    if (expire) begin
      if (s.pending && !clr) n.overrun = 1;
      n.pending = 1;
    end else if (clr) n.pending = 0;
    return n;
  endfunction

  always @(posedge clk or negedge nreset) begin
    if (!nreset) m <= m_reset();
    else         m <= step(m);
  end

  int            pass_cnt = 0;
  int            total_cnt = 0;
  bit            rnd = 0;
  bit            hold_ref = 0;
  int            lat_fix = 4;
  int            lat = 1;
  int            wcnt = 0;
  logic [DW-1:0] dir_rdata = '0;
  logic [1:0]    busy = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic compare_cycle();
    chk("ctl_req", 64'(ctl_req), 64'(m.phase == 1));
    chk("ctl_refresh", 64'(ctl_refresh), 64'(m.phase == 2));
    chk("p0_ready", 64'(p0_ready), 64'(m.phase == 3 && m.port == 0));
    chk("p1_ready", 64'(p1_ready), 64'(m.phase == 3 && m.port == 1));
    chk("refresh_overrun", 64'(refresh_overrun), 64'(m.overrun));
    chk("req_refresh_exclusive", 64'(ctl_req && ctl_refresh), 64'(0));
    if (m.phase == 1) begin
      chk("ctl_nwe", 64'(ctl_nwe), 64'(m.nwe));
      chk("ctl_address", 64'(ctl_address), 64'(m.addr));
      chk("ctl_wdata", 64'(ctl_wdata), 64'(m.wdata));
      chk("ctl_wstrb", 64'(ctl_wstrb), 64'(m.wstrb));
    end
    if (m.phase == 3 && m.port == 0) chk("p0_rdata", 64'(p0_rdata), 64'(m.rdata0));
    if (m.phase == 3 && m.port == 1) chk("p1_rdata", 64'(p1_rdata), 64'(m.rdata1));
  endtask

  task automatic respond();
    if (m.phase == 1 || m.phase == 2) begin
      wcnt++;
      if (wcnt == 1) lat = rnd ? (($urandom % 8 == 0) ? 20 : int'($urandom_range(4, 1))) : lat_fix;
      ctl_ack = (wcnt == lat) && !(m.phase == 2 && hold_ref);
    end else begin
      wcnt = 0;
      ctl_ack = rnd && ($urandom % 8 == 0);
    end
    ctl_rdata = rnd ? $urandom : dir_rdata;
  endtask

  task automatic masters();
    for (int p = 0; p < 2; p++) begin
      if (busy[p] && m.phase == 3 && m.port == p) begin
        busy[p] = 1'b0; vld[p] = 1'b0;
      end else if (!busy[p]) begin
        if ($urandom % 3 == 0) begin
          busy[p] = 1'b1; vld[p] = 1'b1; nwe[p] = 1'($urandom);
          addr[p] = AW'($urandom); wdata[p] = $urandom; wstrb[p] = 4'($urandom);
        end
      end else if (m.phase == 1 && m.port == p) begin
        if ($urandom % 8 == 0) vld[p] = 1'b0;
        if ($urandom % 4 == 0) begin
          nwe[p] = ~nwe[p]; addr[p] = AW'($urandom); wdata[p] = $urandom; wstrb[p] = 4'($urandom);
        end
      end
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      compare_cycle();
      respond();
      if (rnd) masters();
    end
  endtask

  task automatic do_reset();
    nreset = 1'b0;
    vld = '0; busy = '0; rnd = 1'b0; hold_ref = 1'b0;
    cyc(2);
  endtask

  logic [AW-1:0] got [4];
  int            ng;
  logic          prev_req;

  initial begin
    nreset = 1'b0; vld = '0; nwe = '1; ctl_ack = 1'b0; ctl_rdata = '0;
    for (int p = 0; p < 2; p++) begin addr[p] = '0; wdata[p] = '0; wstrb[p] = '0; end
    cyc(2);
    chk("reset_ctl_req", 64'(ctl_req), 64'(0));
    chk("reset_ctl_refresh", 64'(ctl_refresh), 64'(0));
    chk("reset_ctl_nwe", 64'(ctl_nwe), 64'(1));
    chk("reset_ctl_address", 64'(ctl_address), 64'(0));
    chk("reset_ctl_wdata", 64'(ctl_wdata), 64'(0));
    chk("reset_ctl_wstrb", 64'(ctl_wstrb), 64'(0));
    chk("reset_ready", 64'({p0_ready, p1_ready}), 64'(0));
    chk("reset_rdata", 64'({p0_rdata, p1_rdata}), 64'(0));
    chk("reset_overrun", 64'(refresh_overrun), 64'(0));

    // Single read on port 0, controller acks four cycles after the request.
    vld[0] = 1'b1; nwe[0] = 1'b1; addr[0] = 21'h00010; wdata[0] = 32'h0; wstrb[0] = 4'hF;
    dir_rdata = 32'hDEADBEEF; lat_fix = 4;
    nreset = 1'b1;
    cyc(1);
    chk("read_req", 64'(ctl_req), 64'(1));
    chk("read_address", 64'(ctl_address), 64'(21'h00010));
    chk("read_nwe", 64'(ctl_nwe), 64'(1));
    cyc(4);
    chk("read_p0_ready", 64'(p0_ready), 64'(1));
    chk("read_p0_rdata", 64'(p0_rdata), 64'(32'hDEADBEEF));
    chk("read_p1_ready", 64'(p1_ready), 64'(0));
    vld[0] = 1'b0;
    cyc(1);
    chk("read_ready_one_cycle", 64'(p0_ready), 64'(0));

    // Contention: both ports write continuously from reset.
    do_reset();
    vld = 2'b11; nwe = 2'b00; addr[0] = 21'h0A000; addr[1] = 21'h0B000; lat_fix = 2;
    nreset = 1'b1;
    ng = 0; prev_req = 1'b0;
    for (int i = 0; i < 4; i++) got[i] = '0;
    for (int i = 0; i < 60; i++) begin
      cyc(1);
      if (ctl_req && !prev_req && ng < 4) begin got[ng] = ctl_address; ng++; end
      prev_req = ctl_req;
    end
    chk("contention_grant_count", 64'(ng), 64'(4));
    for (int i = 0; i < 4; i++) begin
`ifdef SDRAM_ARB_FIXED_PRIORITY_EN
      chk("contention_order", 64'(got[i]), 64'(21'h0A000));
`else
      chk("contention_order", 64'(got[i]), (i % 2 == 0) ? 64'(21'h0A000) : 64'(21'h0B000));
`endif
    end

    // Idle refresh cadence.
    do_reset();
    lat_fix = 1; nreset = 1'b1;
    cyc(16);
    chk("refresh_before_17", 64'(ctl_refresh), 64'(0));
    cyc(1);
    chk("refresh_at_17", 64'(ctl_refresh), 64'(1));
    cyc(1);
    chk("refresh_acked", 64'(ctl_refresh), 64'(0));
    cyc(14);
    chk("refresh_before_33", 64'(ctl_refresh), 64'(0));
    cyc(1);
    chk("refresh_at_33", 64'(ctl_refresh), 64'(1));

    // Refresh expiring under a port 1 write, with port 0 waiting.
    do_reset();
    lat_fix = 6; nreset = 1'b1;
    cyc(12);
    vld[1] = 1'b1; nwe[1] = 1'b0; addr[1] = 21'h1F0F0;
    cyc(1);
    chk("rvr_p1_granted", 64'(ctl_address), 64'(21'h1F0F0));
    vld[0] = 1'b1; nwe[0] = 1'b1; addr[0] = 21'h00ABC;
    cyc(6);
    chk("rvr_p1_ready", 64'(p1_ready), 64'(1));
    chk("rvr_p0_not_ready", 64'(p0_ready), 64'(0));
    vld[1] = 1'b0;
    cyc(2);
    chk("rvr_refresh", 64'(ctl_refresh), 64'(1));
    chk("rvr_no_req", 64'(ctl_req), 64'(0));
    cyc(7);
    chk("rvr_p0_req", 64'(ctl_req), 64'(1));
    chk("rvr_p0_address", 64'(ctl_address), 64'(21'h00ABC));

    // Overrun: refresh never acknowledged.
    do_reset();
    hold_ref = 1'b1; nreset = 1'b1;
    cyc(2 * RI - 1);
    chk("overrun_before", 64'(refresh_overrun), 64'(0));
    cyc(1);
    chk("overrun_set", 64'(refresh_overrun), 64'(1));
    cyc(20);
    chk("overrun_sticky", 64'(refresh_overrun), 64'(1));

    // Reset in the middle of a port 0 write.
    do_reset();
    vld[0] = 1'b1; nwe[0] = 1'b0; addr[0] = 21'h12345; lat_fix = 8; nreset = 1'b1;
    cyc(1);
    chk("midrst_req_before", 64'(ctl_req), 64'(1));
    chk("midrst_nwe_before", 64'(ctl_nwe), 64'(0));
    #2 nreset = 1'b0;
    #1;
    chk("midrst_req_cleared", 64'(ctl_req), 64'(0));
    chk("midrst_nwe_read", 64'(ctl_nwe), 64'(1));
    vld = 2'b11; nwe[1] = 1'b1; addr[1] = 21'h05432;
    cyc(1);
    nreset = 1'b1;
    cyc(1);
    chk("midrst_tie_req", 64'(ctl_req), 64'(1));
    chk("midrst_tie_p0", 64'(ctl_address), 64'(21'h12345));

    // Randomized traffic against the model.
    do_reset();
    rnd = 1'b1; nreset = 1'b1;
    cyc(3000);
    rnd = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
